// File: rtl/mux_rr_arbiter.sv
// Four-requester round-robin arbiter with a hold limit, steering a 4:1 one-bit data mux.
// gnt/select/valid are registered; q is the combinational mux output.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] gnt,
  output logic [1:0] select,
  output logic       valid,
  output logic       q
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, nxt_state;
  logic [3:0] nxt_gnt;
  logic [1:0] nxt_select;
  logic       nxt_valid;
  logic [1:0] ptr, nxt_ptr;
  logic [7:0] cnt, nxt_cnt;

  logic       any_found, other_found;
  logic [1:0] any_idx, other_idx;

  // First set bit of mask visiting start, start+1, ... with 2-bit wraparound.
  function automatic logic [2:0] pick_first(input logic [3:0] mask, input logic [1:0] start);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = start + 2'(k);
      if (!found && mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  assign {any_found, any_idx}     = pick_first(req, ptr);
  assign {other_found, other_idx} = pick_first(req & ~gnt, ptr);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    nxt_state  = state;
    nxt_gnt    = gnt;
    nxt_select = select;
    nxt_valid  = valid;
    nxt_ptr    = ptr;
    nxt_cnt    = cnt;

    unique case (state)
      IDLE: begin
        if (any_found) begin
          nxt_state  = GRANT;
          nxt_gnt    = 4'b0001 << any_idx;
          nxt_select = any_idx;
          nxt_valid  = 1'b1;
          nxt_ptr    = any_idx + 2'd1;
          nxt_cnt    = 8'd0;
        end
      end

      GRANT: begin
        if (req[select]) begin
          if (cnt < HOLD_LAST) begin
            nxt_cnt = cnt + 8'd1;
          end else if (other_found) begin
            nxt_gnt    = 4'b0001 << other_idx;
            nxt_select = other_idx;
            nxt_ptr    = other_idx + 2'd1;
            nxt_cnt    = 8'd0;
          end
          // Limit reached with nobody waiting: keep grant, counter stays saturated.
        end else if (any_found) begin
          nxt_gnt    = 4'b0001 << any_idx;
          nxt_select = any_idx;
          nxt_ptr    = any_idx + 2'd1;
          nxt_cnt    = 8'd0;
        end else begin
          // select deliberately keeps its last value while idle.
          nxt_state = IDLE;
          nxt_gnt   = 4'b0000;
          nxt_valid = 1'b0;
          nxt_cnt   = 8'd0;
        end
      end

      default: nxt_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= 4'b0000;
      select <= 2'b00;
      valid  <= 1'b0;
      ptr    <= 2'd0;
      cnt    <= 8'd0;
    end else begin
      state  <= nxt_state;
      gnt    <= nxt_gnt;
      select <= nxt_select;
      valid  <= nxt_valid;
      ptr    <= nxt_ptr;
      cnt    <= nxt_cnt;
    end
  end

  assign q = valid ? d[select] : 1'b0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (MAX_HOLD=8): reset, round-robin, hold limit,
// saturation, handover/idle, data path and mid-grant reset, all with hand-computed expectations.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt;
  logic [1:0] select;
  logic       valid;
  logic       q;

  int errors = 0;
  int checks = 0;

  mux_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .d      (d),
    .gnt    (gnt),
    .select (select),
    .valid  (valid),
    .q      (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge; inputs and checks happen 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    d     = 4'b1111;

    // Reset with all requesting: outputs cleared and requests ignored.
    do_reset();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_valid", valid, 1'b0);
    check("rst_q", q, 1'b0);
    check("rst_select", select, 2'b00);
    tick();
    check("rst_first_gnt", gnt, 4'b0001);
    check("rst_first_sel", select, 2'd0);
    check("rst_first_valid", valid, 1'b1);

    // Round-robin: each owner drops its request one cycle after being granted.
    req = 4'b1110; tick(); check("rr_1", gnt, 4'b0010);
    req = 4'b1100; tick(); check("rr_2", gnt, 4'b0100);
    req = 4'b1000; tick(); check("rr_3", gnt, 4'b1000);
    check("rr_3_sel", select, 2'd3);
    req = 4'b0111; tick(); check("rr_4", gnt, 4'b0001);

    // Hold limit: two contenders alternate every 8 cycles.
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 8; i++) begin tick(); check($sformatf("hold0_%0d", i), gnt, 4'b0001); end
    for (int i = 0; i < 8; i++) begin tick(); check($sformatf("hold1_%0d", i), gnt, 4'b0010); end
    tick(); check("hold_back", gnt, 4'b0001);

    // Saturation: a lone requester keeps the path, then yields at the limit.
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 20; i++) begin tick(); check($sformatf("sat_%0d", i), gnt, 4'b0100); end
    req = 4'b0101; tick();
    check("sat_yield", gnt, 4'b0001);
    check("sat_yield_sel", select, 2'd0);

    // Handover without an idle cycle, then drop to idle.
    do_reset();
    req = 4'b0100; tick(); check("ho_own", gnt, 4'b0100);
    req = 4'b1000; tick(); check("ho_next", gnt, 4'b1000);
    check("ho_valid", valid, 1'b1);
    req = 4'b0000; d = 4'b1111; tick();
    check("idle_gnt", gnt, 4'b0000);
    check("idle_valid", valid, 1'b0);
    check("idle_sel_hold", select, 2'd3);
    check("idle_q", q, 1'b0);

    // Data path: q tracks d[1] while requester 1 owns the path.
    do_reset();
    req = 4'b0010; tick(); check("dp_gnt", gnt, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      d = (i % 2 == 0) ? 4'b1010 : 4'b0101;
      #1;
      check($sformatf("dp_q_%0d", i), q, (i % 2 == 0) ? 1'b1 : 1'b0);
      tick();
    end

    // Reset mid-grant drops the grant at that edge; restart uses ptr=0.
    rst_n = 1'b0; req = 4'b1111; tick();
    check("mid_rst_gnt", gnt, 4'b0000);
    check("mid_rst_valid", valid, 1'b0);
    check("mid_rst_sel", select, 2'd0);
    rst_n = 1'b1; tick();
    check("mid_rst_regrant", gnt, 4'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
